// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID-stage hazard control: load-use stall, bypass select, flow-change flush, halt
// HAZARD_BYPASS_EN enables forwarding; without it any in-flight producer stalls ID until it reaches WB.

module hazard_ctrl #(
   parameter int ADDR_W      = 5,
   parameter int FWD_STAGES  = 2,
   parameter int LD_LAT      = 1,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_vld,
   input  logic              id_re0,
   input  logic              id_re1,
   input  logic [ADDR_W-1:0] id_p0_addr,
   input  logic [ADDR_W-1:0] id_p1_addr,
   input  logic              id_we,
   input  logic [ADDR_W-1:0] id_dst_addr,
   input  logic              id_ld,
   input  logic              id_hlt,
   input  logic              flow_change,
   output logic              stall_id,
   output logic              iss_vld,
   output logic [2:0]        byp0_sel,
   output logic [2:0]        byp1_sel,
   output logic              halted,
   output logic              hlt_wb
);

`ifdef HAZARD_BYPASS_EN
   localparam bit BYP_EN = 1'b1;
`else
   localparam bit BYP_EN = 1'b0;
`endif

   localparam int WB_STG = FWD_STAGES + 1;

   // Stages 1..FWD_STAGES carry producer info; only the halt marker is needed at WB.
   logic [FWD_STAGES:1] we_q, we_d;
   logic [FWD_STAGES:1] ld_q, ld_d;
   logic [ADDR_W-1:0]   dst_q [1:FWD_STAGES];
   logic [ADDR_W-1:0]   dst_d [1:FWD_STAGES];
   logic [WB_STG:1]     hlt_q, hlt_d;
   logic [1:0]          fl_cnt_q, fl_cnt_d;
   logic                iss_vld_q, iss_vld_d;
   logic [2:0]          byp0_sel_q, byp0_sel_d;
   logic [2:0]          byp1_sel_q, byp1_sel_d;
   logic                halted_q, halted_d;
   logic                hlt_wb_q, hlt_wb_d;

   logic       hit0, hit1, rdy0, rdy1;
   logic [2:0] stg0, stg1;
   logic       kill, hazard, issue;

   function automatic logic stage_rdy(input int k, input logic ld);
      return BYP_EN && (!ld || (k > LD_LAT));
   endfunction

   // Walk oldest to youngest so the youngest producer wins.
   always_comb begin : match
      hit0 = 1'b0;
      hit1 = 1'b0;
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      stg0 = 3'd0;
      stg1 = 3'd0;
      for (int k = FWD_STAGES; k >= 1; k--) begin
         if (id_re0 && (id_p0_addr != '0) && we_q[k] && (dst_q[k] == id_p0_addr)) begin
            hit0 = 1'b1;
            stg0 = 3'(k);
            rdy0 = stage_rdy(k, ld_q[k]);
         end
         if (id_re1 && (id_p1_addr != '0) && we_q[k] && (dst_q[k] == id_p1_addr)) begin
            hit1 = 1'b1;
            stg1 = 3'(k);
            rdy1 = stage_rdy(k, ld_q[k]);
         end
      end
   end

   always_comb begin : ctrl
      kill     = flow_change || (fl_cnt_q != 2'd0);
      hazard   = id_vld && ((hit0 && !rdy0) || (hit1 && !rdy1));
      stall_id = halted_q || (!kill && hazard);
      issue    = id_vld && !stall_id && !kill;

      we_d[1]  = issue && id_we;
      ld_d[1]  = issue && id_ld;
      hlt_d[1] = issue && id_hlt;
      dst_d[1] = issue ? id_dst_addr : '0;
      we_d[FWD_STAGES:2]  = we_q[FWD_STAGES-1:1];
      ld_d[FWD_STAGES:2]  = ld_q[FWD_STAGES-1:1];
      hlt_d[WB_STG:2]     = hlt_q[FWD_STAGES:1];
      for (int k = 2; k <= FWD_STAGES; k++) begin
         dst_d[k] = dst_q[k-1];
      end

      // The flow_change cycle is itself the first killed slot.
      if (flow_change) begin
         fl_cnt_d = 2'(FLUSH_DEPTH - 1);
      end else if (fl_cnt_q != 2'd0) begin
         fl_cnt_d = fl_cnt_q - 2'd1;
      end else begin
         fl_cnt_d = 2'd0;
      end

      iss_vld_d  = issue;
      byp0_sel_d = (BYP_EN && issue && hit0) ? stg0 : 3'd0;
      byp1_sel_d = (BYP_EN && issue && hit1) ? stg1 : 3'd0;
      halted_d   = halted_q || (issue && id_hlt);
      hlt_wb_d   = hlt_wb_q || hlt_q[WB_STG];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= '0;
         ld_q       <= '0;
         hlt_q      <= '0;
         dst_q      <= '{default: '0};
         fl_cnt_q   <= 2'd0;
         iss_vld_q  <= 1'b0;
         byp0_sel_q <= 3'd0;
         byp1_sel_q <= 3'd0;
         halted_q   <= 1'b0;
         hlt_wb_q   <= 1'b0;
      end else begin
         we_q       <= we_d;
         ld_q       <= ld_d;
         hlt_q      <= hlt_d;
         dst_q      <= dst_d;
         fl_cnt_q   <= fl_cnt_d;
         iss_vld_q  <= iss_vld_d;
         byp0_sel_q <= byp0_sel_d;
         byp1_sel_q <= byp1_sel_d;
         halted_q   <= halted_d;
         hlt_wb_q   <= hlt_wb_d;
      end
   end

   assign iss_vld  = iss_vld_q;
   assign byp0_sel = byp0_sel_q;
   assign byp1_sel = byp1_sel_q;
   assign halted   = halted_q;
   assign hlt_wb   = hlt_wb_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl (expectations follow HAZARD_BYPASS_EN)

module tb_hazard_ctrl;

`ifdef HAZARD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_vld, id_re0, id_re1, id_we, id_ld, id_hlt, flow_change;
   logic [4:0] id_p0_addr, id_p1_addr, id_dst_addr;
   logic       stall_id, iss_vld, halted, hlt_wb;
   logic [2:0] byp0_sel, byp1_sel;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_vld     (id_vld),
      .id_re0     (id_re0),
      .id_re1     (id_re1),
      .id_p0_addr (id_p0_addr),
      .id_p1_addr (id_p1_addr),
      .id_we      (id_we),
      .id_dst_addr(id_dst_addr),
      .id_ld      (id_ld),
      .id_hlt     (id_hlt),
      .flow_change(flow_change),
      .stall_id   (stall_id),
      .iss_vld    (iss_vld),
      .byp0_sel   (byp0_sel),
      .byp1_sel   (byp1_sel),
      .halted     (halted),
      .hlt_wb     (hlt_wb)
   );

   typedef struct {
      logic       vld;
      logic       re0;
      logic [4:0] a0;
      logic       re1;
      logic [4:0] a1;
      logic       we;
      logic [4:0] dst;
      logic       ld;
      logic       hlt;
      logic       fc;
      logic       st;
      logic       iss;
      logic [2:0] b0;
      logic [2:0] b1;
      logic       hl;
      logic       hw;
   } vec_t;

   vec_t cur;
   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s vec=%0d actual=%0d required=%0d", nm, idx, act, req);
      end
   endtask

   task automatic set_i(input logic vld, input logic re0, input logic [4:0] a0, input logic re1,
                        input logic [4:0] a1, input logic we, input logic [4:0] dst,
                        input logic ld, input logic hlt, input logic fc);
      cur.vld = vld; cur.re0 = re0; cur.a0 = a0; cur.re1 = re1; cur.a1 = a1;
      cur.we = we; cur.dst = dst; cur.ld = ld; cur.hlt = hlt; cur.fc = fc;
   endtask

   task automatic mk(input logic st, input logic iss, input logic [2:0] b0, input logic [2:0] b1,
                     input logic hl, input logic hw);
      cur.st = st; cur.iss = iss; cur.b0 = b0; cur.b1 = b1; cur.hl = hl; cur.hw = hw;
   endtask

   task automatic ex(input logic st, input logic iss, input logic [2:0] b0, input logic [2:0] b1,
                     input logic hl, input logic hw);
      mk(st, iss, b0, b1, hl, hw);
      tbl.push_back(cur);
   endtask

   task automatic drive(input vec_t v);
      id_vld = v.vld; id_re0 = v.re0; id_p0_addr = v.a0; id_re1 = v.re1; id_p1_addr = v.a1;
      id_we = v.we; id_dst_addr = v.dst; id_ld = v.ld; id_hlt = v.hlt; flow_change = v.fc;
   endtask

   task automatic chk_regs(input int idx, input vec_t v);
      chk("iss_vld", idx, iss_vld, v.iss);
      chk("byp0_sel", idx, byp0_sel, v.b0);
      chk("byp1_sel", idx, byp1_sel, v.b1);
      chk("halted", idx, halted, v.hl);
      chk("hlt_wb", idx, hlt_wb, v.hw);
   endtask

   task automatic step(input vec_t v, input int idx);
      @(negedge clk);
      drive(v);
      #1;
      chk("stall_id", idx, stall_id, v.st);
      @(posedge clk);
      #1;
      chk_regs(idx, v);
   endtask

   initial begin
      rst_n = 1'b0;
      set_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mk(0, 0, 0, 0, 0, 0);
      drive(cur);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall_id", -1, stall_id, 1'b0);
      chk_regs(-1, cur);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU producer, back-to-back and one-apart consumers
      set_i(1, 1, 1, 1, 2, 1, 3, 0, 0, 0); ex(0, 1, 0, 0, 0, 0);
      set_i(1, 1, 3, 1, 1, 1, 4, 0, 0, 0);
      if (BYP) ex(0, 1, 1, 0, 0, 0);
      else begin ex(1, 0, 0, 0, 0, 0); ex(1, 0, 0, 0, 0, 0); ex(0, 1, 0, 0, 0, 0); end
      set_i(1, 1, 7, 1, 8, 1, 6, 0, 0, 0); ex(0, 1, 0, 0, 0, 0);
      set_i(1, 1, 4, 1, 7, 1, 9, 0, 0, 0);
      if (BYP) ex(0, 1, 2, 0, 0, 0);
      else begin ex(1, 0, 0, 0, 0, 0); ex(0, 1, 0, 0, 0, 0); end
      set_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(0, 0, 0, 0, 0, 0); ex(0, 0, 0, 0, 0, 0);

      // load-use on port 1, R0 destination, read-enable gating
      set_i(1, 1, 1, 0, 0, 1, 5, 1, 0, 0); ex(0, 1, 0, 0, 0, 0);
      set_i(1, 1, 2, 1, 5, 1, 10, 0, 0, 0); ex(1, 0, 0, 0, 0, 0);
      if (BYP) ex(0, 1, 0, 2, 0, 0);
      else begin ex(1, 0, 0, 0, 0, 0); ex(0, 1, 0, 0, 0, 0); end
      set_i(1, 1, 1, 0, 0, 1, 0, 1, 0, 0); ex(0, 1, 0, 0, 0, 0);
      set_i(1, 1, 0, 1, 0, 1, 11, 0, 0, 0); ex(0, 1, 0, 0, 0, 0);
      set_i(1, 0, 11, 0, 0, 1, 12, 0, 0, 0); ex(0, 1, 0, 0, 0, 0);

      // flush of two slots, then reload during an active flush
      set_i(1, 1, 1, 1, 2, 1, 13, 0, 0, 1); ex(0, 0, 0, 0, 0, 0);
      set_i(1, 1, 1, 1, 2, 1, 13, 0, 0, 0); ex(0, 0, 0, 0, 0, 0);
      set_i(1, 1, 1, 1, 2, 1, 14, 0, 0, 0); ex(0, 1, 0, 0, 0, 0);
      set_i(1, 1, 1, 1, 2, 1, 15, 0, 0, 1); ex(0, 0, 0, 0, 0, 0); ex(0, 0, 0, 0, 0, 0);
      set_i(1, 1, 1, 1, 2, 1, 15, 0, 0, 0); ex(0, 0, 0, 0, 0, 0); ex(0, 1, 0, 0, 0, 0);

      // flow_change during a load-use stall
      set_i(1, 1, 1, 0, 0, 1, 16, 1, 0, 0); ex(0, 1, 0, 0, 0, 0);
      set_i(1, 1, 16, 1, 1, 1, 17, 0, 0, 0); ex(1, 0, 0, 0, 0, 0);
      set_i(1, 1, 16, 1, 1, 1, 17, 0, 0, 1); ex(0, 0, 0, 0, 0, 0);
      set_i(1, 1, 16, 1, 1, 1, 17, 0, 0, 0); ex(0, 0, 0, 0, 0, 0); ex(0, 1, 0, 0, 0, 0);

      // HLT in flush shadow is dropped
      set_i(1, 1, 1, 1, 2, 1, 18, 0, 0, 1); ex(0, 0, 0, 0, 0, 0);
      set_i(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); ex(0, 0, 0, 0, 0, 0);
      set_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(0, 0, 0, 0, 0, 0); ex(0, 0, 0, 0, 0, 0); ex(0, 0, 0, 0, 0, 0);

      // HLT issues; WB three cycles later
      set_i(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); ex(0, 1, 0, 0, 1, 0);
      set_i(1, 1, 1, 1, 2, 1, 19, 0, 0, 0); ex(1, 0, 0, 0, 1, 0); ex(1, 0, 0, 0, 1, 0);
      ex(1, 0, 0, 0, 1, 1); ex(1, 0, 0, 0, 1, 1);

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // asynchronous reset while halted holds the stall
      @(negedge clk);
      drive(cur);
      #1;
      chk("halt_stall", 90, stall_id, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      mk(0, 0, 0, 0, 0, 0);
      chk("async_stall_id", 90, stall_id, 1'b0);
      chk_regs(90, cur);
      @(negedge clk);
      rst_n = 1'b1;
      set_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(cur);

      // asynchronous reset during a load-use stall, consumer present at release
      set_i(1, 1, 1, 0, 0, 1, 5, 1, 0, 0); mk(0, 1, 0, 0, 0, 0); step(cur, 100);
      @(negedge clk);
      set_i(1, 1, 2, 1, 5, 1, 10, 0, 0, 0);
      drive(cur);
      #1;
      chk("lu_stall", 101, stall_id, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_stall_id", 101, stall_id, 1'b0);
      chk("async_iss_vld", 101, iss_vld, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_stall", 102, stall_id, 1'b0);
      @(posedge clk);
      #1;
      mk(0, 1, 0, 0, 0, 0);
      chk_regs(102, cur);

      set_i(1, 1, 1, 1, 2, 1, 3, 0, 0, 0); mk(0, 1, 0, 0, 0, 0); step(cur, 103);
      set_i(1, 1, 3, 1, 1, 1, 4, 0, 0, 0);
      if (BYP) begin
         mk(0, 1, 1, 0, 0, 0); step(cur, 104);
      end else begin
         mk(1, 0, 0, 0, 0, 0); step(cur, 104); step(cur, 105);
         mk(0, 1, 0, 0, 0, 0); step(cur, 106);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
